// File: rtl/countdown_timer_pkg.sv
// Shared types and constants for the egg-timer countdown path.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package egg_timer_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        LOADED  = 2'd1,
        RUN     = 2'd2,
        EXPIRED = 2'd3
    } state_t;

    // Width of one BCD digit
    localparam int DIGIT_W = 4;

    // Largest legal value of a ones digit and of the seconds-tens digit
    localparam int ONES_MAX     = 9;
    localparam int SEC_TENS_MAX = 5;

endpackage

// File: rtl/countdown_timer_if.sv
// Control inputs and display/status outputs of the countdown timer.
// Latency: n/a (wiring only).
// Backpressure: none; all signals are level/strobe, no handshake.
interface countdown_timer_if #(
    parameter int SIZE = 4
);
    logic            load;
    logic [7:0]      preset_min;
    logic [7:0]      preset_sec;
    logic            is_counting;
    logic            sec_clk;
    logic            ack;
    logic [SIZE-1:0] min_tens;
    logic [SIZE-1:0] min_ones;
    logic [SIZE-1:0] sec_tens;
    logic [SIZE-1:0] sec_ones;
    logic            running;
    logic            done;
    logic            alarm;

    // Side that drives controls and watches the display
    modport master (
        output load, preset_min, preset_sec, is_counting, sec_clk, ack,
        input  min_tens, min_ones, sec_tens, sec_ones, running, done, alarm
    );

    // Timer side
    modport slave (
        input  load, preset_min, preset_sec, is_counting, sec_clk, ack,
        output min_tens, min_ones, sec_tens, sec_ones, running, done, alarm
    );
endinterface

// File: rtl/countdown_timer_bcd_down_digit.sv
// One BCD down-counting digit with clamped load and borrow chain.
// Latency: 1 clk from load/dec to digit; borrow_out is combinational.
// Backpressure: none; load has priority over decrement.
module bcd_down_digit
    import egg_timer_pkg::*;
#(
    parameter int W   = DIGIT_W,
    parameter int MAX = ONES_MAX
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    input  logic         borrow_in,
    output logic [W-1:0] digit,
    output logic         borrow_out
);

    localparam logic [W-1:0] MAX_V = W'(MAX);

    logic [W-1:0] digit_q;

    // This digit underflows (and so borrows from the next) only when it is
    // actually being decremented while already at zero.
    assign borrow_out = dec & borrow_in & (digit_q == '0);
    assign digit      = digit_q;

    // Digit register: clamped load, else decrement with wrap to MAX
    always_ff @(posedge clk) begin
        if (!rst) begin
            digit_q <= '0;
        end else if (load) begin
            digit_q <= (load_val > MAX_V) ? MAX_V : load_val;
        end else if (dec && borrow_in) begin
            digit_q <= (digit_q == '0) ? MAX_V : digit_q - W'(1);
        end
    end

endmodule

// File: rtl/countdown_timer.sv
// mm:ss BCD countdown driven by sec_clk rising edges, with expiry alarm.
// Latency: 1 clk from the tick/load cycle to registered digits/state.
// Backpressure: none; load beats tick and ack, ack beats tick in EXPIRED.
module countdown_timer
    import egg_timer_pkg::*;
#(
    parameter int SIZE        = DIGIT_W,
    parameter int ALARM_TICKS = 30
) (
    input  logic                clk,
    input  logic                rst,
    countdown_timer_if.slave    bus
);

    localparam int              CNT_W    = (ALARM_TICKS > 1) ? $clog2(ALARM_TICKS) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ALARM_TICKS - 1);

    state_t           state;
    logic             sec_clk_q;
    logic             alarm_q;
    logic [CNT_W-1:0] alarm_cnt;

    logic             tick;
    logic             dec;
    logic             at_zero;
    logic             at_one;

    logic [SIZE-1:0]  mt, mo, st, so;
    logic             b_so, b_st, b_mo, b_mt;

    // Rising edge of sec_clk; sec_clk_q resets high so a high sec_clk at
    // reset release does not count as a tick.
    assign tick = bus.sec_clk & ~sec_clk_q;

    assign at_zero = (mt == '0) && (mo == '0) && (st == '0) && (so == '0);
    assign at_one  = (mt == '0) && (mo == '0) && (st == '0) && (so == SIZE'(1));

    // Decrement on a running tick; never decrement from 00:00 (that tick
    // goes straight to EXPIRED instead) and never on a load cycle.
    assign dec = !bus.load && tick && bus.is_counting && !at_zero &&
                 ((state == LOADED) || (state == RUN));

    bcd_down_digit #(.W(SIZE), .MAX(ONES_MAX)) u_sec_ones (
        .clk        (clk),
        .rst        (rst),
        .load       (bus.load),
        .load_val   (SIZE'(bus.preset_sec[3:0])),
        .dec        (dec),
        .borrow_in  (1'b1),
        .digit      (so),
        .borrow_out (b_so)
    );

    bcd_down_digit #(.W(SIZE), .MAX(SEC_TENS_MAX)) u_sec_tens (
        .clk        (clk),
        .rst        (rst),
        .load       (bus.load),
        .load_val   (SIZE'(bus.preset_sec[7:4])),
        .dec        (dec),
        .borrow_in  (b_so),
        .digit      (st),
        .borrow_out (b_st)
    );

    bcd_down_digit #(.W(SIZE), .MAX(ONES_MAX)) u_min_ones (
        .clk        (clk),
        .rst        (rst),
        .load       (bus.load),
        .load_val   (SIZE'(bus.preset_min[3:0])),
        .dec        (dec),
        .borrow_in  (b_st),
        .digit      (mo),
        .borrow_out (b_mo)
    );

    // The minutes-tens borrow is never consumed: 00:01 expires before any
    // decrement could underflow the top digit.
    bcd_down_digit #(.W(SIZE), .MAX(ONES_MAX)) u_min_tens (
        .clk        (clk),
        .rst        (rst),
        .load       (bus.load),
        .load_val   (SIZE'(bus.preset_min[7:4])),
        .dec        (dec),
        .borrow_in  (b_mo),
        .digit      (mt),
        .borrow_out (b_mt)
    );

    // Control FSM, tick edge register and alarm blink/timeout counter
    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= IDLE;
            sec_clk_q <= 1'b1;
            alarm_q   <= 1'b0;
            alarm_cnt <= '0;
        end else begin
            sec_clk_q <= bus.sec_clk;
            if (bus.load) begin
                state     <= LOADED;
                alarm_q   <= 1'b0;
                alarm_cnt <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        state <= IDLE;
                    end
                    LOADED: begin
                        if (bus.is_counting && tick) begin
                            if (at_zero || at_one) begin
                                state     <= EXPIRED;
                                alarm_q   <= 1'b1;
                                alarm_cnt <= '0;
                            end else begin
                                state <= RUN;
                            end
                        end
                    end
                    RUN: begin
                        // Pause is checked ahead of the tick
                        if (!bus.is_counting) begin
                            state <= LOADED;
                        end else if (tick && (at_one || at_zero)) begin
                            state     <= EXPIRED;
                            alarm_q   <= 1'b1;
                            alarm_cnt <= '0;
                        end
                    end
                    EXPIRED: begin
                        if (bus.ack) begin
                            state     <= IDLE;
                            alarm_q   <= 1'b0;
                            alarm_cnt <= '0;
                        end else if (tick) begin
                            if (alarm_cnt == CNT_LAST) begin
                                state     <= IDLE;
                                alarm_q   <= 1'b0;
                                alarm_cnt <= '0;
                            end else begin
                                alarm_cnt <= alarm_cnt + CNT_W'(1);
                                alarm_q   <= ~alarm_q;
                            end
                        end
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

    assign bus.min_tens = mt;
    assign bus.min_ones = mo;
    assign bus.sec_tens = st;
    assign bus.sec_ones = so;
    assign bus.running  = (state == RUN);
    assign bus.done     = (state == EXPIRED);
    assign bus.alarm    = alarm_q;

endmodule

// File: tb/tb_countdown_timer.sv
// Directed self-checking bench for countdown_timer.
// Latency: checks sample on negedge, one clk after each driven event.
// Backpressure: n/a.
module tb_countdown_timer;

    logic clk;
    logic rst;
    int   checks;
    int   failures;

    countdown_timer_if #(.SIZE(4)) bus ();

    countdown_timer #(.SIZE(4), .ALARM_TICKS(30)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] mmss();
        return {bus.min_tens, bus.min_ones, bus.sec_tens, bus.sec_ones};
    endfunction

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic status(input string tag, input logic [15:0] t, input logic r,
                          input logic d, input logic a);
        check({tag, "_time"}, mmss(), t);
        check({tag, "_running"}, {15'd0, bus.running}, {15'd0, r});
        check({tag, "_done"}, {15'd0, bus.done}, {15'd0, d});
        check({tag, "_alarm"}, {15'd0, bus.alarm}, {15'd0, a});
    endtask

    // One sec_clk rising edge seen by exactly one clk edge; ends on a negedge
    task automatic tick();
        @(negedge clk);
        bus.sec_clk = 1'b1;
        @(negedge clk);
        bus.sec_clk = 1'b0;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic do_load(input logic [7:0] m, input logic [7:0] s);
        @(negedge clk);
        bus.load       = 1'b1;
        bus.preset_min = m;
        bus.preset_sec = s;
        @(negedge clk);
        bus.load = 1'b0;
    endtask

    initial begin
        checks          = 0;
        failures        = 0;
        rst             = 1'b0;
        bus.load        = 1'b0;
        bus.preset_min  = 8'h00;
        bus.preset_sec  = 8'h00;
        bus.is_counting = 1'b0;
        bus.sec_clk     = 1'b1;
        bus.ack         = 1'b0;

        // 1: reset release with sec_clk high
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        status("reset", 16'h0000, 1'b0, 1'b0, 1'b0);
        bus.sec_clk = 1'b0;
        @(negedge clk);

        // 2: 01:00 counts down through 00:00
        do_load(8'h01, 8'h00);
        status("load0100", 16'h0100, 1'b0, 1'b0, 1'b0);
        bus.is_counting = 1'b1;
        tick();
        status("first_tick", 16'h0059, 1'b1, 1'b0, 1'b0);
        ticks(58);
        status("at_0001", 16'h0001, 1'b1, 1'b0, 1'b0);
        tick();
        status("expired", 16'h0000, 1'b0, 1'b1, 1'b1);

        // 5: alarm blinks, ack coincident with a tick wins
        tick();
        check("blink1", {15'd0, bus.alarm}, 16'd0);
        tick();
        check("blink2", {15'd0, bus.alarm}, 16'd1);
        tick();
        status("blink3", 16'h0000, 1'b0, 1'b1, 1'b0);
        @(negedge clk);
        bus.ack     = 1'b1;
        bus.sec_clk = 1'b1;
        @(negedge clk);
        bus.ack     = 1'b0;
        bus.sec_clk = 1'b0;
        status("ack_tick", 16'h0000, 1'b0, 1'b0, 1'b0);
        tick();
        status("idle_ignores_tick", 16'h0000, 1'b0, 1'b0, 1'b0);

        // 3: multi-digit borrows
        do_load(8'h10, 8'h00);
        tick();
        check("triple_borrow", mmss(), 16'h0959);
        do_load(8'h00, 8'h10);
        tick();
        check("tens_borrow", mmss(), 16'h0009);

        // ack outside EXPIRED is ignored
        @(negedge clk);
        bus.ack = 1'b1;
        @(negedge clk);
        bus.ack = 1'b0;
        status("ack_in_run", 16'h0009, 1'b1, 1'b0, 1'b0);

        // 4: clamping, pause and resume
        do_load(8'hAF, 8'h7C);
        status("clamp", 16'h9959, 1'b0, 1'b0, 1'b0);
        do_load(8'h00, 8'h31);
        tick();
        status("at_0030", 16'h0030, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        bus.is_counting = 1'b0;
        @(negedge clk);
        status("paused", 16'h0030, 1'b0, 1'b0, 1'b0);
        ticks(5);
        status("paused_5", 16'h0030, 1'b0, 1'b0, 1'b0);
        bus.is_counting = 1'b1;
        @(negedge clk);
        check("resume_wait", mmss(), 16'h0030);
        tick();
        status("resumed", 16'h0029, 1'b1, 1'b0, 1'b0);

        // 00:00 loaded and ticked goes straight to EXPIRED; plain ack clears
        do_load(8'h00, 8'h00);
        tick();
        status("zero_load", 16'h0000, 1'b0, 1'b1, 1'b1);
        @(negedge clk);
        bus.ack = 1'b1;
        @(negedge clk);
        bus.ack = 1'b0;
        status("ack_plain", 16'h0000, 1'b0, 1'b0, 1'b0);

        // 6: unacknowledged alarm times out after exactly 30 ticks
        do_load(8'h00, 8'h02);
        tick();
        check("run_0001", mmss(), 16'h0001);
        tick();
        status("exp2", 16'h0000, 1'b0, 1'b1, 1'b1);
        ticks(29);
        status("tick29", 16'h0000, 1'b0, 1'b1, 1'b0);
        tick();
        status("timeout", 16'h0000, 1'b0, 1'b0, 1'b0);

        // load coincident with a tick in RUN wins
        do_load(8'h00, 8'h20);
        tick();
        check("run_0019", mmss(), 16'h0019);
        @(negedge clk);
        bus.load       = 1'b1;
        bus.preset_min = 8'h00;
        bus.preset_sec = 8'h45;
        bus.sec_clk    = 1'b1;
        @(negedge clk);
        bus.load    = 1'b0;
        bus.sec_clk = 1'b0;
        status("load_tick", 16'h0045, 1'b0, 1'b0, 1'b0);

        // reset in the middle of a run
        tick();
        status("run_0044", 16'h0044, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        status("mid_reset", 16'h0000, 1'b0, 1'b0, 1'b0);
        rst = 1'b1;
        tick();
        status("after_reset", 16'h0000, 1'b0, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
